// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: decoder ALU codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_pkg;

    // Decoder alucontrol codes, shared with the decoder and main ALU
    localparam logic [2:0] ALU_MULU = 3'b011;
    localparam logic [2:0] ALU_DIVU = 3'b111;
    localparam logic [2:0] ALU_MFHI = 3'b100;
    localparam logic [2:0] ALU_MFLO = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Decoder-to-muldiv bundle: issue strobe, ALU code, operands, read value, status and HI/LO.
// Latency: n/a (wires only).
// Backpressure: stall is returned to the decoder while an mfhi/mflo hits a busy unit.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // master: instruction decoder side
    modport master (
        output start, alucontrol, srca, srcb,
        input  result, busy, done, stall, hi, lo
    );

    // slave: the multiply/divide unit
    modport slave (
        input  start, alucontrol, srca, srcb,
        output result, busy, done, stall, hi, lo
    );

endinterface

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none. Ports: rem/dbit/divisor in, rem_next/qbit out.
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             qbit
);

    // One extra bit over the remainder so the sign of the trial difference is explicit
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem, dbit};
        diff     = shifted - {2'b00, divisor};
        qbit     = ~diff[WIDTH+1];
        rem_next = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multu/divu with HI/LO registers plus mfhi/mflo read-out.
// Latency: WIDTH+1 cycles issue-to-done (multu is 1 cycle when MULDIV_FAST_MUL_EN is defined).
// Backpressure: starts while busy are dropped; stall asks the decoder to hold an mfhi/mflo.
// Ports: clk, reset (sync, active-high), bus (muldiv_if.slave).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             last;

    // Divide datapath
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   rem_n;
    logic             qbit;

    assign last = (cnt == CW'(WIDTH - 1));

    divu_step #(.WIDTH(WIDTH)) u_divu_step (
        .rem      (rem),
        .dbit     (quo[WIDTH-1]),
        .divisor  (dvsr),
        .rem_next (rem_n),
        .qbit     (qbit)
    );

`ifdef MULDIV_FAST_MUL_EN
`else
    // Shift-add multiply: multiplicand moves left, multiplier moves right
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_n;

    assign acc_n = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
`ifdef MULDIV_FAST_MUL_EN
`else
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && bus.alucontrol == ALU_MULU) begin
`ifdef MULDIV_FAST_MUL_EN
                        {hi, lo} <= {{WIDTH{1'b0}}, bus.srca} * {{WIDTH{1'b0}}, bus.srcb};
                        done     <= 1'b1;
`else
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, bus.srca};
                        mplier <= bus.srcb;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_MUL;
`endif
                    end else if (bus.start && bus.alucontrol == ALU_DIVU) begin
                        rem   <= '0;
                        quo   <= bus.srca;
                        dvsr  <= bus.srcb;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_DIV;
                    end
                end
`ifdef MULDIV_FAST_MUL_EN
`else
                ST_MUL: begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        hi    <= acc_n[2*WIDTH-1:WIDTH];
                        lo    <= acc_n[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
`endif
                ST_DIV: begin
                    // Dividend bits leave the top of quo while quotient bits enter the bottom.
                    // A zero divisor always "succeeds", yielding all-ones and remainder = dividend.
                    rem <= rem_n;
                    quo <= {quo[WIDTH-2:0], qbit};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        lo    <= {quo[WIDTH-2:0], qbit};
                        hi    <= rem_n[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.result = '0;
        if (bus.alucontrol == ALU_MFHI)
            bus.result = hi;
        else if (bus.alucontrol == ALU_MFLO)
            bus.result = lo;
    end

    assign bus.stall = busy & bus.start &
                       ((bus.alucontrol == ALU_MFHI) | (bus.alucontrol == ALU_MFLO));
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.hi    = hi;
    assign bus.lo    = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset state, multu/divu results and latency, stall, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its done cycle (bounded)
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat;
        int busy_low;
        int exp_lat;
        exp_lat = (op == ALU_MULU) ? MUL_LAT : DIV_LAT;
        bus.start      = 1'b1;
        bus.alucontrol = op;
        bus.srca       = a;
        bus.srcb       = b;
        step();
        bus.start = 1'b0;
        lat       = 1;
        busy_low  = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_low++;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_gaps"}, 64'(busy_low), 64'd0);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        int stall_bad;
        int done_seen;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.alucontrol = 3'b000;
        bus.srca       = '0;
        bus.srcb       = '0;
        step();
        step();
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_done",   64'(bus.done),   64'd0);
        chk("rst_hi",     64'(bus.hi),     64'd0);
        chk("rst_lo",     64'(bus.lo),     64'd0);
        chk("rst_stall",  64'(bus.stall),  64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        reset = 1'b0;
        step();

        // 2^16 * 2^16 = 2^32
        run_op("mul_2p32", ALU_MULU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        step();
        chk("mul_done_one_cycle", 64'(bus.done), 64'd0);

        run_op("mul_max", ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        bus.alucontrol = ALU_MFHI;
        #2;
        chk("mfhi_result", 64'(bus.result), 64'hFFFF_FFFE);
        bus.alucontrol = ALU_MFLO;
        #2;
        chk("mflo_result", 64'(bus.result), 64'h0000_0001);
        bus.alucontrol = ALU_MULU;
        #2;
        chk("other_result", 64'(bus.result), 64'd0);

        // divu issued back-to-back in the previous op's done cycle
        run_op("div_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_by_0", ALU_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("mul_6_7", ALU_MULU, 32'd6, 32'd7, 32'd0, 32'd42);
        step();

        // mfhi/mflo held while a divide is in flight; a multu is slipped in mid-way
        bus.start      = 1'b1;
        bus.alucontrol = ALU_DIVU;
        bus.srca       = 32'd50;
        bus.srcb       = 32'd5;
        step();
        stall_bad = 0;
        done_seen = 0;
        for (int c = 1; c <= W; c++) begin
            if (c == 5) begin
                bus.alucontrol = ALU_MULU;
                bus.srca       = 32'd3;
                bus.srcb       = 32'd3;
            end else begin
                bus.alucontrol = ALU_MFLO;
            end
            #2;
            if (c == 5)
                chk("stall_multu_busy", 64'(bus.stall), 64'd0);
            else if (bus.stall !== 1'b1)
                stall_bad++;
            if (bus.done === 1'b1) done_seen++;
            step();
        end
        chk("stall_held", 64'(stall_bad), 64'd0);
        chk("stall_no_early_done", 64'(done_seen), 64'd0);
        bus.alucontrol = ALU_MFLO;
        #2;
        chk("stall_drop", 64'(bus.stall), 64'd0);
        chk("stall_done", 64'(bus.done), 64'd1);
        chk("stall_mflo", 64'(bus.result), 64'd10);
        bus.alucontrol = ALU_MFHI;
        #2;
        chk("stall_mfhi", 64'(bus.result), 64'd0);
        bus.start = 1'b0;
        step();
        chk("ignored_mul_busy", 64'(bus.busy), 64'd0);
        chk("ignored_mul_lo", 64'(bus.lo), 64'd10);
        chk("ignored_mul_hi", 64'(bus.hi), 64'd0);

        // Reset in cycle 10 of a divide
        run_op("div_pre_rst", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        step();
        bus.start      = 1'b1;
        bus.alucontrol = ALU_DIVU;
        bus.srca       = 32'h0000_FFFF;
        bus.srcb       = 32'd3;
        step();
        bus.start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done === 1'b1) done_seen++;
            step();
        end
        chk("rst_mid_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hi",   64'(bus.hi),   64'd0);
        chk("rst_mid_lo",   64'(bus.lo),   64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) done_seen++;
            step();
        end
        chk("rst_mid_no_done", 64'(done_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the instruction decoder, beside the main ALU. It consumes the decoder's `alucontrol` codes for `multu`/`divu`/`mfhi`/`mflo` together with the register-file operands. It returns the `mfhi`/`mflo` read value and a stall request that freezes the PC while a read hits an unfinished operation.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; iteration count equals `WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: decoder issue strobe for the current instruction (R-type, regwrite path).
- `alucontrol` in 3: decoder ALU code: 3'b011 `multu`, 3'b111 `divu`, 3'b100 `mfhi`, 3'b101 `mflo`; other codes are ignored.
- `srca` in WIDTH: rs operand (multiplicand / dividend).
- `srcb` in WIDTH: rt operand (multiplier / divisor).
- `result` out WIDTH: combinational; HI for `mfhi`, LO for `mflo`, 0 otherwise.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse in the first cycle new HI/LO are visible.
- `stall` out 1: combinational; `busy & start & (alucontrol == mfhi | alucontrol == mflo)`.
- `hi`, `lo` out WIDTH each: architectural HI/LO registers.

## Operation
- States: IDLE, MUL, DIV.
- Reset values:
  - state = IDLE; `busy` = 0, `done` = 0.
  - `hi` = `lo` = 0; iteration counter = 0.
- Accept: in IDLE with `start = 1` and `alucontrol` = `multu` or `divu`:
  - latch `srca`/`srcb`; clear counter.
  - go to MUL or DIV respectively.
- `start` with any other code, or while busy, has no effect on state or HI/LO.
- MUL (shift-add):
  - 2·WIDTH-bit product accumulator.
  - Each cycle, add the shifted multiplicand if the current multiplier bit is 1; shift.
  - After WIDTH iterations: `hi` = product[2W-1:W], `lo` = product[W-1:0]; return to IDLE.
- DIV (restoring):
  - (WIDTH+1)-bit partial remainder.
  - Each cycle, shift in the next dividend bit and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; else restore and set it to 0.
  - After WIDTH iterations: `lo` = quotient, `hi` = remainder.
- Divide by zero is defined, not undefined: `lo` = all ones, `hi` = dividend, with the full normal latency.
- All arithmetic is unsigned; overflow beyond 2·WIDTH bits is impossible.

## Timing
- Cycle 0: accept.
- Cycles 1..WIDTH: `busy` = 1.
- HI/LO are written at the edge ending cycle WIDTH.
- Cycle WIDTH+1: `busy` = 0, `done` = 1, and new HI/LO are visible. Latency is WIDTH+1 cycles (33 for WIDTH = 32).
- A new `start` is accepted in the same cycle `done` is high; back-to-back issue is possible.
- `mfhi`/`mflo` while `busy`:
  - `stall` is held high through cycle WIDTH.
  - `stall` drops in cycle WIDTH+1, when `result` already reflects the new value.
- Reset mid-operation:
  - next cycle is IDLE with `busy` = 0 and HI = LO = 0.
  - no `done` pulse; the partial result is discarded.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - `multu` is single-cycle using the synthesis `*` operator.
  - HI/LO are written at the edge ending cycle 0; `done` = 1 in cycle 1.
  - `busy` is never asserted for `multu`; the MUL state and multiply accumulator are removed.
- Undefined: iterative shift-add as above, with WIDTH+1 latency.
- `divu` is iterative in both builds.

## Structure
- Package `muldiv_pkg`:
  - `alucontrol` code constants (`ALU_MULU`, `ALU_DIVU`, `ALU_MFHI`, `ALU_MFLO`), shared with the decoder and ALU.
  - state enum.
- One sub-module: `divu_step`, purely combinational. It takes the remainder, next dividend bit and divisor, and returns the new remainder and quotient bit.
- The FSM, counter, accumulators and HI/LO stay in `muldiv_unit`.

## Test plan
- Reset, then `multu` 0x0001_0000 × 0x0001_0000 → after 33 cycles HI = 0x0000_0001, LO = 0x0000_0000; `done` high for exactly 1 cycle.
- `multu` 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- `divu` 100 / 7 → LO = 14, HI = 2; `divu` 0x1234 / 0 → LO = 0xFFFF_FFFF, HI = 0x0000_1234.
- Issue `divu` 50 / 5, then hold `mfhi`/`mflo` with `start` from cycle 1:
  - `stall` = 1 through cycle 32; cycle 33 gives `stall` = 0 and `result` = LO = 10 (or HI = 0).
  - a `multu` start during busy is ignored.
- Assert `reset` in cycle 10 of a `divu` → cycle 11 has `busy` = 0 and HI = LO = 0; `done` never pulses.
- With `MULDIV_FAST_MUL_EN`: `multu` 6 × 7 → cycle 1 has LO = 42, HI = 0, `done` = 1, and `busy` never high.
